// File: rtl/registers_pkg.sv
// Shared definitions for the parallel register path: state encoding and a
// width helper used to size bit counters.
package registers_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter with enable and zero flag; saturates at zero so a
// stray enable can never wrap the count.
module bit_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shifter with valid/ready load and per-bit shift
// enable; a word may reload on its own last bit for gap-free streaming.
module piso_shift_register
  import registers_pkg::*;
#(
  parameter int n         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [n-1:0] I,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         frame_start,
  output logic         frame_done
);

  localparam int CW = clog2(n);
  localparam logic [CW-1:0] LAST_CNT = CW'(n - 1);

  state_e       state_q, state_d;
  logic [n-1:0] shift_q, shift_d;
  logic         frame_done_q, frame_done_d;
  logic [CW-1:0] count;
  logic         count_zero;
  logic         shifting;
  logic         last_bit;
  logic         load_fire;
  logic [n-1:0] shifted;

  assign shifting  = (state_q == SHIFT) && shift_en;
  assign last_bit  = shifting && count_zero;
  // Ready depends combinationally on shift_en so the next word can be taken
  // on the same edge that consumes the last bit.
  assign load_ready = (state_q == IDLE) || last_bit;
  assign load_fire  = load_valid && load_ready;

  assign shifted = MSB_FIRST ? {shift_q[n-2:0], 1'b0} : {1'b0, shift_q[n-1:1]};

  bit_down_counter #(
    .W(CW)
  ) u_count (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load_fire),
    .load_value(LAST_CNT),
    .en        (shifting),
    .count     (count),
    .zero      (count_zero)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    frame_done_d = last_bit;
    if (load_fire) begin
      state_d = SHIFT;
      shift_d = I;
    end else if (shifting) begin
      shift_d = shifted;
      if (count_zero) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sout_valid  = (state_q == SHIFT);
  assign sout        = sout_valid && (MSB_FIRST ? shift_q[n-1] : shift_q[0]);
  assign frame_start = sout_valid && (count == LAST_CNT);
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register: an MSB-first and an LSB-first
// instance share stimulus and are checked each cycle against a word/index model.
module tb_piso_shift_register;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] I = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;

  logic ready_m, sout_m, valid_m, start_m, done_m;
  logic ready_l, sout_l, valid_l, start_l, done_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_shift_register #(.n(N), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .I(I), .load_valid(load_valid),
    .load_ready(ready_m), .shift_en(shift_en), .sout(sout_m),
    .sout_valid(valid_m), .frame_start(start_m), .frame_done(done_m)
  );

  piso_shift_register #(.n(N), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .I(I), .load_valid(load_valid),
    .load_ready(ready_l), .shift_en(shift_en), .sout(sout_l),
    .sout_valid(valid_l), .frame_start(start_l), .frame_done(done_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the word in flight and how many of its bits were already consumed.
  logic         m_busy = 1'b0;
  logic [N-1:0] m_word = '0;
  int           m_k = 0;
  logic         m_done = 1'b0;

  function automatic logic m_ready();
    return !m_busy || (m_k == N - 1 && shift_en);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0;
      m_word = '0;
      m_k    = 0;
      m_done = 1'b0;
    end else begin
      logic rdy;
      rdy    = m_ready();
      m_done = m_busy && (m_k == N - 1) && shift_en;
      if (m_busy && shift_en) begin
        if (m_k == N - 1) m_busy = 1'b0;
        else m_k++;
      end
      if (load_valid && rdy) begin
        m_word = I;
        m_busy = 1'b1;
        m_k    = 0;
      end
    end
  end

  logic [15:0] cap_m = '0;
  logic [15:0] cap_l = '0;
  int          done_cnt_m = 0;
  int          done_cnt_l = 0;
  int          busy_ready_cnt = 0;

  always @(negedge clk) begin
    logic exp_sout_m, exp_sout_l;
    exp_sout_m = m_busy ? m_word[N-1-m_k] : 1'b0;
    exp_sout_l = m_busy ? m_word[m_k] : 1'b0;
    chk("msb sout", sout_m, exp_sout_m);
    chk("msb sout_valid", valid_m, m_busy);
    chk("msb frame_start", start_m, m_busy && m_k == 0);
    chk("msb frame_done", done_m, m_done);
    chk("msb load_ready", ready_m, m_ready());
    chk("lsb sout", sout_l, exp_sout_l);
    chk("lsb sout_valid", valid_l, m_busy);
    chk("lsb frame_start", start_l, m_busy && m_k == 0);
    chk("lsb frame_done", done_l, m_done);
    chk("lsb load_ready", ready_l, m_ready());
    if (reset_n && valid_m && shift_en) cap_m = {cap_m[14:0], sout_m};
    if (reset_n && valid_l && shift_en) cap_l = {sout_l, cap_l[15:1]};
    if (done_m) done_cnt_m++;
    if (done_l) done_cnt_l++;
    if (ready_m && valid_m && load_valid) busy_ready_cnt++;
  end

  task automatic step(input int cycles = 1);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [N-1:0] w);
    I = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    int base_m, base_l, base_r;
    bit accepted;

    step(2);
    chk("reset sout_valid", valid_m, 1'b0);
    chk("reset sout", sout_m, 1'b0);
    reset_n = 1'b1;
    step();
    chk("idle load_ready", ready_m, 1'b1);

    // Basic word, both bit orders.
    base_m = done_cnt_m; base_l = done_cnt_l;
    shift_en = 1'b1;
    send_word(8'hA5);
    chk("A5 first bit msb", sout_m, 1'b1);
    chk("A5 frame_start", start_m, 1'b1);
    step(10);
    chk("A5 msb bits", cap_m[7:0], 8'hA5);
    chk("A5 lsb bits", cap_l[15:8], 8'hA5);
    chk("A5 done msb", done_cnt_m - base_m, 1);
    chk("A5 done lsb", done_cnt_l - base_l, 1);
    chk("A5 idle ready", ready_m, 1'b1);
    $display("txn A5 msb=%h lsb=%h", cap_m[7:0], cap_l[15:8]);

    send_word(8'h01);
    chk("01 lsb first bit", sout_l, 1'b1);
    chk("01 msb first bit", sout_m, 1'b0);
    step(10);
    chk("01 msb bits", cap_m[7:0], 8'h01);
    chk("01 lsb bits", cap_l[15:8], 8'h01);
    $display("txn 01 msb=%h lsb=%h", cap_m[7:0], cap_l[15:8]);

    // Stall after two consumed bits.
    send_word(8'hF0);
    step();
    shift_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("stall sout", sout_m, 1'b1);
      chk("stall valid", valid_m, 1'b1);
    end
    shift_en = 1'b1;
    step(10);
    chk("F0 msb bits", cap_m[7:0], 8'hF0);
    $display("txn F0 stalled msb=%h", cap_m[7:0]);

    // Back-to-back streaming.
    base_m = done_cnt_m; base_r = busy_ready_cnt;
    I = 8'hA5;
    load_valid = 1'b1;
    step();
    I = 8'h3C;
    accepted = 1'b0;
    for (int t = 0; t < 20 && !accepted; t++) begin
      accepted = ready_m;
      step();
    end
    load_valid = 1'b0;
    chk("b2b accepted", accepted, 1'b1);
    step(12);
    chk("b2b msb bits", cap_m, 16'hA53C);
    chk("b2b lsb bits", cap_l, 16'h3CA5);
    chk("b2b done pulses", done_cnt_m - base_m, 2);
    chk("b2b ready cycles", busy_ready_cnt - base_r, 1);
    $display("txn b2b msb=%h lsb=%h", cap_m, cap_l);

    // Busy load ignored, then async reset after four bits.
    base_m = done_cnt_m;
    send_word(8'hA5);
    I = 8'hFF;
    load_valid = 1'b1;
    step(3);
    load_valid = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst sout", sout_m, 1'b0);
    chk("rst sout_valid", valid_m, 1'b0);
    chk("rst frame_start", start_m, 1'b0);
    chk("rst frame_done", done_m, 1'b0);
    chk("busy msb partial", cap_m[3:0], 4'hA);
    chk("busy lsb partial", cap_l[15:12], 4'h5);
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("post rst ready", ready_m, 1'b1);
    chk("post rst valid", valid_m, 1'b0);
    chk("rst no done", done_cnt_m - base_m, 0);
    $display("txn busy+reset partial msb=%h", cap_m[3:0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
- Parallel-in, serial-out shift register with a valid/ready load handshake and a bit-level output enable.
- Takes an n-bit word from a parallel register stage and serialises it one bit per accepted shift.
- This is the reader/transmitter end of the team's parallel register path, feeding serial links (SPI-like, UART-like data paths).
- Supports back-to-back words with no idle cycle.

Parameters:
- n, 8, word width in bits. Legal range n >= 2.
- MSB_FIRST, 1, 1 = shift out bit n-1 first; 0 = shift out bit 0 first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- I  input  n  parallel word to serialise.
- load_valid  input  1  upstream has a word on I.
- load_ready  output  1  block accepts I this cycle.
- shift_en  input  1  downstream consumes the current sout bit this cycle.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout holds a valid data bit.
- frame_start  output  1  sout is the first bit of a word.
- frame_done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; shift_reg=0; bit count=0.
  - sout=0, sout_valid=0, frame_start=0, frame_done=0.
  - load_ready=1 as soon as reset deasserts.
- State machine has two states, IDLE and SHIFT.
- IDLE:
  - load_ready=1, sout_valid=0, sout=0.
  - When load_valid=1, on the clock edge: shift_reg<=I, count<=n-1, state<=SHIFT.
- SHIFT:
  - sout_valid=1.
  - sout = shift_reg[n-1] if MSB_FIRST, otherwise shift_reg[0].
  - frame_start=1 while count==n-1.
- Shift with shift_en=1 and count>0:
  - shift_reg shifts toward the output end; a 0 fills the vacated bit.
  - count decrements.
- Hold with shift_en=0: shift_reg, count and state are all held; sout stays stable, with no bit loss.
- Last bit (count==0 and shift_en=1):
  - frame_done pulses 1 on the next cycle.
  - If load_valid=1 in the same cycle, the new word loads directly (state stays SHIFT, count<=n-1). This gives zero-gap streaming.
  - Otherwise state<=IDLE.
- load_ready:
  - load_ready = (state==IDLE) OR (state==SHIFT AND count==0 AND shift_en).
  - This is a combinational path from shift_en, and it is intentional.
- Busy: load_valid while load_ready=0 is ignored and I is not sampled. Upstream must hold I and load_valid until it sees load_ready.
- Latency: the first bit appears on sout the cycle after load is accepted. A word occupies exactly n accepted shifts.
- Count register width is clog2(n). No wrap-around: count never decrements below 0.
- Reset mid-frame aborts the word immediately. No frame_done is issued and there is no partial output after reset.
- I changing while in SHIFT has no effect.

Decomposition:
- Shared package (registers_pkg) holds:
  - State encoding: IDLE=1'b0, SHIFT=1'b1.
  - Count-width helper function clog2.
- One sub-module is natural: bit_down_counter. It is a parameterized down-counter with load, enable and zero flag, clocked by clk with async reset_n, and can be reused by the future SIPO receiver.

Test Plan:
- Basic MSB-first: n=8, MSB_FIRST=1, I=8'hA5, load_valid for 1 cycle, shift_en=1 -> sout=1,0,1,0,0,1,0,1 on 8 consecutive cycles; frame_start on the first bit only; frame_done pulse the cycle after the 8th bit; then IDLE with load_ready=1.
- LSB-first: MSB_FIRST=0, I=8'hA5 -> sout=1,0,1,0,0,1,0,1 reversed order (bit0 first: 1,0,1,0,0,1,0,1 for A5 is symmetric). Also check I=8'h01 -> 1 then seven 0s.
- Stall: I=8'hF0, shift_en low for 3 cycles after the 2nd bit -> sout held at 1 for 4 cycles total, the full sequence still 1,1,1,1,0,0,0,0, and sout_valid stays 1 throughout.
- Back-to-back: I=8'hA5 then 8'h3C, with load_valid held and shift_en=1 -> 16 contiguous valid bits with no gap; load_ready high only on the 8th bit cycle; frame_done pulses twice.
- Busy and reset: load_valid with I=8'hFF during a frame -> ignored, and the original bits are unaltered. Drop reset_n asynchronously at bit 4 -> all outputs 0 immediately, no frame_done, and load_ready=1 after release.
